// File: rtl/instr_mem_loader.sv
// Instruction memory for the RV32I fetch port: packs a little-endian byte stream
// into words, holds the core in reset while loading, then serves fetches combinationally.
module instr_mem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              saat,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    input  logic [31:0]       ps,
    output logic [31:0]       buyruk,
    output logic              core_reset,
    output logic              load_done,
    output logic              fault,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned     CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH_WORDS - 1);
    localparam logic [31:0]     NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t             state, state_next;
    logic [1:0]         lane, lane_next;
    logic [31:0]        word_buf, buf_next, wr_data;
    logic               wr_en;
    logic               core_reset_next, load_done_next, fault_next;
    logic [CNT_W-1:0]   count_next;
    logic               fetch_bad;
    logic [31:0]        mem [DEPTH_WORDS];

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge saat) begin
        if (reset) begin
            state      <= IDLE;
            lane       <= 2'd0;
            word_buf   <= 32'd0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            fault      <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_next;
            lane       <= lane_next;
            word_buf   <= buf_next;
            core_reset <= core_reset_next;
            load_done  <= load_done_next;
            fault      <= fault_next;
            word_count <= count_next;
        end
    end

    // Memory contents survive reset; a word pending on the reset edge is dropped.
    always_ff @(posedge saat) begin
        if (!reset && wr_en) begin
            mem[word_count[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Misaligned or beyond the loaded program is an illegal fetch.
    assign fetch_bad = (ps[1:0] != 2'b00) || (ps[31:2] >= 30'(word_count));

    always_comb begin
        buyruk = NOP;
        if (state == RUN && !fetch_bad) begin
            buyruk = mem[ps[ADDR_W+1:2]];
        end
    end

    // Next-state, byte packing and handshake.
    always_comb begin
        state_next = state;
        lane_next  = lane;
        buf_next   = word_buf;
        count_next = word_count;
        fault_next = fault;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_data    = word_buf;
        wr_data[{lane, 3'b000} +: 8] = in_byte;

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = (word_count < DEPTH_CNT);
                if (in_valid && in_ready) begin
                    if (lane == 2'd3 || in_last) begin
                        wr_en      = 1'b1;
                        count_next = word_count + CNT_W'(1);
                        lane_next  = 2'd0;
                        buf_next   = 32'd0;
                        if (in_last) begin
                            state_next = RUN;
                        end else if (word_count == LAST_IDX) begin
                            state_next = RUN;
                            fault_next = 1'b1;
                        end
                    end else begin
                        lane_next = lane + 2'd1;
                        buf_next  = wr_data;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next = LOAD;
                    count_next = '0;
                    lane_next  = 2'd0;
                    buf_next   = 32'd0;
                    fault_next = 1'b0;
                end else if (fetch_bad) begin
                    fault_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        core_reset_next = (state_next != RUN);
        load_done_next  = (state_next == RUN);
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: full-depth instance plus a 4-word instance for overflow.
module tb_instr_mem_loader;

    logic        saat;
    logic        rst_a, rst_b;
    logic        load_start, in_valid, in_last;
    logic [7:0]  in_byte;
    logic [31:0] ps;

    logic        a_in_ready, a_core_reset, a_load_done, a_fault;
    logic [31:0] a_buyruk;
    logic [8:0]  a_word_count;

    logic        b_in_ready, b_core_reset, b_load_done, b_fault;
    logic [31:0] b_buyruk;
    logic [2:0]  b_word_count;

    int errors = 0;
    int checks = 0;

    instr_mem_loader #(.DEPTH_WORDS(256), .ADDR_W(8)) dut_a (
        .saat(saat), .reset(rst_a), .load_start(load_start),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_byte(in_byte),
        .in_last(in_last), .ps(ps), .buyruk(a_buyruk),
        .core_reset(a_core_reset), .load_done(a_load_done),
        .fault(a_fault), .word_count(a_word_count)
    );

    instr_mem_loader #(.DEPTH_WORDS(4), .ADDR_W(2)) dut_b (
        .saat(saat), .reset(rst_b), .load_start(load_start),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_byte(in_byte),
        .in_last(in_last), .ps(ps), .buyruk(b_buyruk),
        .core_reset(b_core_reset), .load_done(b_load_done),
        .fault(b_fault), .word_count(b_word_count)
    );

    initial begin
        saat = 1'b0;
        forever #5 saat = ~saat;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge saat);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic start);
        in_valid   = 1'b1;
        in_byte    = b;
        in_last    = last;
        load_start = start;
        step();
        in_valid   = 1'b0;
        in_last    = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    logic [7:0] prog [8];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_byte = 8'h00; ps = 32'd0;
        prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h50; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'h10; prog[7] = 8'h00;
        step(); step();

        check("rst core_reset", 32'(a_core_reset), 32'd1);
        check("rst load_done", 32'(a_load_done), 32'd0);
        check("rst fault", 32'(a_fault), 32'd0);
        check("rst word_count", 32'(a_word_count), 32'd0);
        check("rst in_ready", 32'(a_in_ready), 32'd0);
        check("rst buyruk", a_buyruk, 32'h13);

        // Two-word program.
        rst_a = 1'b0;
        step();
        check("idle in_ready", 32'(a_in_ready), 32'd0);
        pulse_start();
        check("load in_ready", 32'(a_in_ready), 32'd1);
        check("load core_reset", 32'(a_core_reset), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(prog[i], (i == 7), 1'b0);
        end
        check("prog word_count", 32'(a_word_count), 32'd2);
        check("prog load_done", 32'(a_load_done), 32'd1);
        check("prog core_reset", 32'(a_core_reset), 32'd0);
        check("prog in_ready", 32'(a_in_ready), 32'd0);
        check("prog fault", 32'(a_fault), 32'd0);
        ps = 32'd0; #1;
        check("fetch ps0", a_buyruk, 32'h0050_0513);
        ps = 32'd4; #1;
        check("fetch ps4", a_buyruk, 32'h0010_0593);
        step();
        check("legal no fault", 32'(a_fault), 32'd0);

        // Fetch beyond program end.
        ps = 32'd8; #1;
        check("fetch ps8 nop", a_buyruk, 32'h13);
        step();
        ps = 32'd0;
        check("oob fault", 32'(a_fault), 32'd1);
        step();
        check("fault sticky", 32'(a_fault), 32'd1);
        check("sticky fetch ps0", a_buyruk, 32'h0050_0513);

        // Reload with a partial word.
        pulse_start();
        check("reload fault", 32'(a_fault), 32'd0);
        check("reload core_reset", 32'(a_core_reset), 32'd1);
        check("reload word_count", 32'(a_word_count), 32'd0);
        check("reload load_done", 32'(a_load_done), 32'd0);
        check("reload buyruk nop", a_buyruk, 32'h13);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        check("partial word_count", 32'(a_word_count), 32'd1);
        check("partial buyruk", a_buyruk, 32'h00CC_BBAA);
        ps = 32'd4; #1;
        check("partial ps4 nop", a_buyruk, 32'h13);
        ps = 32'd2; #1;
        check("misaligned nop", a_buyruk, 32'h13);
        step();
        ps = 32'd0;
        check("misaligned fault", 32'(a_fault), 32'd1);
        pulse_start();
        check("restart fault", 32'(a_fault), 32'd0);
        check("restart core_reset", 32'(a_core_reset), 32'd1);
        check("restart word_count", 32'(a_word_count), 32'd0);

        // Reset in the middle of a load discards the partial lane.
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        check("midload word_count", 32'(a_word_count), 32'd1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("midrst core_reset", 32'(a_core_reset), 32'd1);
        check("midrst word_count", 32'(a_word_count), 32'd0);
        check("midrst in_ready", 32'(a_in_ready), 32'd0);
        send(8'hEE, 1'b1, 1'b0);
        check("idle ignores byte", 32'(a_word_count), 32'd0);
        pulse_start();
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b1, 1'b1);
        check("after rst load_done", 32'(a_load_done), 32'd1);
        check("after rst word_count", 32'(a_word_count), 32'd1);
        check("after rst mem0", a_buyruk, 32'h0403_0201);

        // Overflow on the 4-word instance.
        rst_a = 1'b1;
        rst_b = 1'b0;
        step();
        check("b in_ready idle", 32'(b_in_ready), 32'd0);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0, 1'b0);
        end
        check("ovf load_done", 32'(b_load_done), 32'd1);
        check("ovf fault", 32'(b_fault), 32'd1);
        check("ovf word_count", 32'(b_word_count), 32'd4);
        check("ovf in_ready", 32'(b_in_ready), 32'd0);
        check("ovf core_reset", 32'(b_core_reset), 32'd0);
        ps = 32'd12; #1;
        check("ovf mem3", b_buyruk, 32'h0F0E_0D0C);
        ps = 32'd4; #1;
        check("ovf mem1", b_buyruk, 32'h0706_0504);
        step();
        check("ovf in_ready later", 32'(b_in_ready), 32'd0);
        check("ovf fault held", 32'(b_fault), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction-memory block serving the single-cycle RV32I core's fetch port. It accepts a program as a little-endian byte stream over a valid/ready handshake and packs it into words. While loading, it holds the core in reset. Once loading completes, it answers the core's `ps` with the addressed word on `buyruk` in the same cycle.

## Interface
- `DEPTH_WORDS`, 256: instruction memory depth in 32-bit words.
- `ADDR_W`, 8: word-index width; `2**ADDR_W` must be ≥ `DEPTH_WORDS`.

Ports:
- `saat` in 1: clock; all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `load_start` in 1: one-cycle request to begin (re)loading a program.
- `in_valid` in 1: `in_byte` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `in_byte` in 8: program byte, little-endian within each word.
- `in_last` in 1: qualifies the final byte of the program.
- `ps` in 32: program counter from the core.
- `buyruk` out 32: instruction for `ps`; combinational.
- `core_reset` out 1: registered; drives the core's `reset`.
- `load_done` out 1: registered; high in RUN.
- `fault` out 1: registered, sticky; set on an illegal fetch or overflow.
- `word_count` out ADDR_W+1: registered; number of words written in the current load.

## Operation
- States: IDLE, LOAD, RUN.
- Reset values: state=IDLE, `core_reset`=1, `load_done`=0, `fault`=0, `word_count`=0, byte-lane counter=0, word buffer=0. Memory contents are not cleared.
- IDLE:
  - `in_ready`=0; input bytes are ignored.
  - `load_start` moves to LOAD.
- LOAD:
  - `in_ready` = 1 while `word_count` < `DEPTH_WORDS`.
  - A byte is accepted on `in_valid && in_ready`.
  - Lane 0 goes to bits [7:0], lane 1 to [15:8], lane 2 to [23:16], lane 3 to [31:24].
  - On lane 3, or on any byte with `in_last`: the assembled word is written to `mem[word_count]`, `word_count`+1, and lanes reset to 0. Unfilled upper lanes are written as 0.
  - `in_last` accepted moves to RUN.
  - Writing word index `DEPTH_WORDS-1` without `in_last` moves to RUN and sets `fault` (overflow).
  - `load_start` in LOAD is ignored.
- RUN:
  - `core_reset`=0, `load_done`=1, `in_ready`=0.
  - Fetch index = `ps[31:2]`.
  - If `ps[1:0]`≠0 or the index ≥ `word_count`: `buyruk` = 32'h0000_0013 (NOP, addi x0,x0,0), and `fault` is set on the next edge.
  - Otherwise `buyruk` = `mem[ps[ADDR_W+1:2]]`.
  - `load_start` moves to LOAD and, on that edge, clears `word_count`, the lanes, `fault` and `load_done`, and sets `core_reset`.
- Outside RUN, `buyruk` = NOP.
- `reset` overrides every other input.
- `core_reset` = (next state ≠ RUN), registered.

## Timing
- Byte acceptance is one per cycle at full throughput; `in_ready` does not depend combinationally on `in_valid`.
- Edge N accepts the final byte. On edge N, the word write, the transition to RUN, and `core_reset`→0 all take effect.
- The core sits at `ps`=0 after edge N. Its first fetch is in cycle N+1 and already sees the written word: read-after-write across that edge is required.
- `buyruk` has zero-cycle latency from `ps`; there is no registered read.
- `fault` asserts on the edge following the illegal fetch cycle.
- Simultaneous `load_start` and a final byte in LOAD: the final byte wins and the state becomes RUN.
- `reset` asserted mid-LOAD: on that edge the state becomes IDLE and partial lanes are discarded. The core stays in reset.

## Test plan
- Load bytes 13 05 50 00, 93 05 10 00 with `in_last` on the 8th byte:
  - `word_count`=2, `load_done`=1, `core_reset` falls on the same edge.
  - `ps`=0 gives `buyruk`=0x00500513; `ps`=4 gives 0x00100593.
- Partial word: 3 bytes AA BB CC with `in_last` → `mem[0]`=0x00CCBBAA, `word_count`=1.
- In RUN, `ps`=8 with `word_count`=2 → `buyruk`=0x00000013; `fault`=1 next cycle and stays set.
- In RUN, `ps`=2 → NOP and `fault`=1. Then `load_start` → LOAD, `fault`=0, `core_reset`=1, `word_count`=0.
- Overflow with `DEPTH_WORDS`=4:
  - 16 bytes sent without `in_last` → RUN, `fault`=1, `word_count`=4.
  - `in_ready`=0 from that edge on.
- `reset` asserted after 5 bytes mid-LOAD → IDLE, `core_reset`=1, `word_count`=0, `in_ready`=0.
  - A new `load_start` plus 4 bytes → a correct `mem[0]`.
